// File: rtl/alu_seq_if.sv
// Handshake bundle between an operand-issuing controller and the sequential ALU.
// No logic and no latency of its own.
// Backpressure: in_valid/in_ready on the issue side, out_valid/out_ready on the result side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             c_out;
  logic             of;

  // Controller / result-consumer side
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, c_out, of
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, c_out, of
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: 8 single-cycle ops plus iterative shifts (1 bit/cycle) and shift-add multiply.
// Latency: result visible 1 edge after accept, +s edges for shifts, +WIDTH edges for mul.
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;     // multiplicand for mul
  logic [WIDTH-1:0] work_q;  // shift register, or multiplier / low product half
  logic [WIDTH-1:0] hi_q;    // high product half during mul
  logic [CW-1:0]    cnt_q;   // remaining iterations
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             c_q;
  logic             of_q;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic             lt_s;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_long;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_of;

  // One iteration of the multi-cycle datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] hi_d;
  logic             step_c;

  assign add_w    = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign lt_s     = $signed(bus.a) < $signed(bus.b);
  assign shamt    = bus.b[SHW-1:0];
  assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
  // Zero-amount shifts complete immediately and pass a through unchanged
  assign is_long  = (is_shift && (shamt != '0)) || (bus.op == OP_MUL);

  // Result and flags for everything that completes on the accept edge
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_of  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT:  sc_res = ~bus.a;
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_SLL, OP_SRL, OP_SRA: sc_res = bus.a;
      default: sc_res = '0;
    endcase
  end

  // Next value of the iterative datapath for one BUSY cycle
  always_comb begin
    work_d  = work_q;
    hi_d    = hi_q;
    step_c  = 1'b0;
    mul_sum = '0;
    case (op_q)
      OP_SLL: begin
        work_d = {work_q[WIDTH-2:0], 1'b0};
        step_c = work_q[WIDTH-1];
      end
      OP_SRL: begin
        work_d = {1'b0, work_q[WIDTH-1:1]};
        step_c = work_q[0];
      end
      OP_SRA: begin
        work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_c = work_q[0];
      end
      OP_MUL: begin
        // Add multiplicand when the current multiplier bit is set, then shift the
        // {carry, hi, lo} product right; lo fills with product bits as b drains out
        mul_sum        = {1'b0, hi_q} + (work_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        {hi_d, work_d} = {mul_sum, work_q[WIDTH-1:1]};
        step_c         = |hi_d;
      end
      default: begin
        work_d = work_q;
        hi_d   = hi_q;
      end
    endcase
  end

  // Control FSM with registered handshake outputs, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      work_q      <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      c_q         <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            a_q        <= bus.a;
            in_ready_q <= 1'b0;
            hi_q       <= '0;
            if (is_long) begin
              state_q <= BUSY;
              work_q  <= (bus.op == OP_MUL) ? bus.b : bus.a;
              cnt_q   <= (bus.op == OP_MUL) ? CNT_MUL : {1'b0, shamt};
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              work_q      <= bus.a;
              cnt_q       <= '0;
              result_q    <= sc_res;
              zero_q      <= (sc_res == '0);
              c_q         <= sc_c;
              of_q        <= sc_of;
            end
          end
        end
        BUSY: begin
          work_q <= work_d;
          hi_q   <= hi_d;
          cnt_q  <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= work_d;
            zero_q      <= (work_d == '0);
            c_q         <= step_c;
            of_q        <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.c_out     = c_q;
  assign bus.of        = of_q;

endmodule
